// File: rtl/t_pulse_debouncer.sv
// Push-button debouncer: synchronizes a raw bouncing button and emits one t_out pulse per press.
// Optional auto-repeat while held is enabled by defining AUTOREPEAT_EN.
module t_pulse_debouncer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_CYCLES   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_in,
    output logic       t_out,
    output logic       btn_level,
    output logic [7:0] press_cnt
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [1:0] {StIdle, StWaitHigh, StPressed, StWaitLow} state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_sync;
    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   t_out_q, t_out_d;
    logic                   level_q, level_d;
    logic [7:0]             press_q, press_d;

`ifdef AUTOREPEAT_EN
    localparam int unsigned RepW = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_CYCLES - 1);

    logic [RepW-1:0] rep_q, rep_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
        end
    end

    assign btn_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            t_out_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            t_out_q <= t_out_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        t_out_d = 1'b0;
        level_d = level_q;
        press_d = press_q;
`ifdef AUTOREPEAT_EN
        rep_d   = '0;
`endif
        unique case (state_q)
            StIdle: begin
                if (btn_sync) begin
                    state_d = StWaitHigh;
                    cnt_d   = CntOne;
                end else begin
                    cnt_d   = '0;
                end
            end
            StWaitHigh: begin
                if (!btn_sync) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                    t_out_d = 1'b1;
                    level_d = 1'b1;
                    press_d = press_q + 8'd1;
                end else begin
                    cnt_d   = cnt_q + CntOne;
                end
            end
            StPressed: begin
`ifdef AUTOREPEAT_EN
                if (rep_q == RepLast) begin
                    t_out_d = 1'b1;
                    press_d = press_q + 8'd1;
                end else begin
                    rep_d   = rep_q + RepW'(1);
                end
`endif
                if (!btn_sync) begin
                    state_d = StWaitLow;
                    cnt_d   = CntOne;
                end
            end
            StWaitLow: begin
`ifdef AUTOREPEAT_EN
                // Repeat phase is frozen during a release bounce; re-entry to pressed restarts it.
                rep_d = btn_sync ? '0 : rep_q;
`endif
                if (btn_sync) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d   = cnt_q + CntOne;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign t_out     = t_out_q;
    assign btn_level = level_q;
    assign press_cnt = press_q;

endmodule
